// File: rtl/stc_pkg.sv
// Shared types and constants for the multi-lane serial two's-complement block.
package stc_pkg;

    localparam int STC_MIN_W = 2;

    typedef enum logic {
        COPY   = 1'b0,
        INVERT = 1'b1
    } lane_state_e;

    // Bit-counter width; W below the legal minimum still yields a 1-bit counter.
    function automatic int stc_k_width(input int w);
        return (w <= STC_MIN_W) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_twos_comp_mc_if.sv
// Serial stream bundle: input bit lanes with framing, registered result lanes.
interface serial_twos_comp_mc_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_sof;
    logic [N-1:0] in_bit;
    logic [N-1:0] mode;
    logic         out_valid;
    logic [N-1:0] out_bit;
    logic         out_eow;
    logic [N-1:0] ovf;

    modport master (
        output in_valid, in_sof, in_bit, mode,
        input  out_valid, out_bit, out_eow, ovf
    );

    modport slave (
        input  in_valid, in_sof, in_bit, mode,
        output out_valid, out_bit, out_eow, ovf
    );

endinterface

// File: rtl/stc_lane.sv
// One serial lane: copy bits up to and including the first 1, then invert (negate mode).
module stc_lane
    import stc_pkg::*;
(
    input  logic t_clk,
    input  logic r_n,
    input  logic i_valid,
    input  logic i_first,
    input  logic i_last,
    input  logic i_bit,
    input  logic i_mode,
    output logic o_bit,
    output logic o_ovf
);

    lane_state_e r_state;
    lane_state_e w_state_cur;
    lane_state_e w_state_nxt;
    logic        r_mode;
    logic        w_mode_cur;
    logic        w_out;
    logic        w_ovf;
    logic        r_bit;
    logic        r_ovf;

    // Bit 0 always starts in COPY and uses the live mode, not the latched one.
    assign w_state_cur = i_first ? COPY : r_state;
    assign w_mode_cur  = i_first ? i_mode : r_mode;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_state <= COPY;
            r_mode  <= 1'b0;
        end else if (i_valid) begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_cur;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = w_state_cur;
        if (w_state_cur == COPY && w_mode_cur && i_bit)
            w_state_nxt = INVERT;
    end

    // A negate lane still in COPY at the MSB saw all-zero low bits, so an MSB of 1 means -2^(W-1).
    always_comb begin
        w_out = i_bit;
        w_ovf = 1'b0;
        if (w_state_cur == INVERT)
            w_out = ~i_bit;
        if (i_last && w_mode_cur && w_state_cur == COPY && i_bit)
            w_ovf = 1'b1;
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_bit <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (i_valid)
                r_bit <= w_out;
            r_ovf <= i_valid & w_ovf;
        end
    end

    assign o_bit = r_bit;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/serial_twos_comp_mc.sv
// N-lane serial (LSB-first) pass/negate unit with a shared bit counter and 1-cycle latency.
module serial_twos_comp_mc
    import stc_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                  t_clk,
    input  logic                  r_n,
    serial_twos_comp_mc_if.slave  bus
);

    localparam int KW = stc_k_width(W);

    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k;
    logic          w_first;
    logic          w_last;
    logic          r_out_valid;
    logic          r_out_eow;
    logic [N-1:0]  w_out_bit;
    logic [N-1:0]  w_ovf;

    // in_sof forces this bit to index 0, abandoning any partial word.
    assign w_k     = bus.in_sof ? '0 : r_k;
    assign w_first = (w_k == '0);
    assign w_last  = (w_k == KW'(W - 1));

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_eow   <= 1'b0;
        end else begin
            if (bus.in_valid)
                r_k <= w_last ? '0 : w_k + KW'(1);
            r_out_valid <= bus.in_valid;
            r_out_eow   <= bus.in_valid & w_last;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        stc_lane u_lane (
            .t_clk   (t_clk),
            .r_n     (r_n),
            .i_valid (bus.in_valid),
            .i_first (w_first),
            .i_last  (w_last),
            .i_bit   (bus.in_bit[g]),
            .i_mode  (bus.mode[g]),
            .o_bit   (w_out_bit[g]),
            .o_ovf   (w_ovf[g])
        );
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_eow   = r_out_eow;
    assign bus.out_bit   = w_out_bit;
    assign bus.ovf       = w_ovf;

endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Scoreboard bench: a W=4/N=1 and a W=8/N=4 instance checked against a word-level arithmetic model.
module tb_serial_twos_comp_mc;

    typedef struct packed {
        logic [3:0] bits;
        logic       eow;
        logic [3:0] ovf;
    } exp_t;

    logic t_clk = 1'b0;
    logic r_n   = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic       last_a;
    logic [3:0] last_b;
    bit   aligned[2];

    always #5 t_clk = ~t_clk;

    serial_twos_comp_mc_if #(.N(1)) bus_a ();
    serial_twos_comp_mc_if #(.N(4)) bus_b ();

    serial_twos_comp_mc #(.W(4), .N(1)) dut_a (.t_clk(t_clk), .r_n(r_n), .bus(bus_a.slave));
    serial_twos_comp_mc #(.W(8), .N(4)) dut_b (.t_clk(t_clk), .r_n(r_n), .bus(bus_b.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; idle lanes get random sof/bit/mode to show they are ignored.
    task automatic tick();
        @(posedge t_clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_a.in_sof   = 1'($urandom);
        bus_b.in_sof   = 1'($urandom);
        bus_a.in_bit   = 1'($urandom);
        bus_b.in_bit   = 4'($urandom);
        bus_a.mode     = 1'($urandom);
        bus_b.mode     = 4'($urandom);
    endtask

    // Word-level model: result = x or (-x) mod 2^W; overflow only when negating -2^(W-1).
    task automatic send_word(input int d, input logic [3:0][7:0] x, input logic [3:0] md,
                             input int nbits, input bit use_sof, input int gap_at, input int gap_len);
        int   w    = (d == 0) ? 4 : 8;
        int   n    = (d == 0) ? 1 : 4;
        int   mask = (1 << w) - 1;
        int   r[4];
        logic [3:0] ov;
        exp_t e;
        logic [3:0] bits;
        logic [3:0] modes;
        ov = '0;
        for (int i = 0; i < 4; i++) begin
            int xm = int'(x[i]) & mask;
            r[i] = 0;
            if (i < n) begin
                r[i]  = md[i] ? ((-xm) & mask) : xm;
                ov[i] = md[i] && (xm == (1 << (w - 1)));
            end
        end
        for (int b = 0; b < nbits; b++) begin
            if (b == gap_at)
                repeat (gap_len) tick();
            e = '0;
            for (int i = 0; i < n; i++) begin
                bits[i]   = x[i][b];
                e.bits[i] = 1'((r[i] >> b) & 1);
            end
            e.eow = (b == w - 1);
            e.ovf = e.eow ? ov : 4'b0;
            modes = (b == 0) ? md : 4'($urandom);
            if (d == 0) begin
                bus_a.in_valid = 1'b1;
                bus_a.in_sof   = (b == 0) ? use_sof : 1'b0;
                bus_a.in_bit   = bits[0];
                bus_a.mode     = modes[0];
                qa.push_back(e);
            end else begin
                bus_b.in_valid = 1'b1;
                bus_b.in_sof   = (b == 0) ? use_sof : 1'b0;
                bus_b.in_bit   = bits;
                bus_b.mode     = modes;
                qb.push_back(e);
            end
            tick();
        end
        aligned[d] = (nbits == w);
    endtask

    always @(negedge t_clk) begin
        exp_t e;
        if (!r_n) begin
            check("a_rst_out", {bus_a.out_valid, bus_a.out_bit, bus_a.out_eow, bus_a.ovf}, 0);
            check("b_rst_out", {bus_b.out_valid, bus_b.out_bit, bus_b.out_eow, bus_b.ovf}, 0);
            last_a = 1'b0;
            last_b = '0;
        end else begin
            if (bus_a.out_valid) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL a_unexpected: got out_valid=1 expected no output at %0t", $time);
                end else begin
                    e = qa.pop_front();
                    check("a_bit", bus_a.out_bit, e.bits[0]);
                    check("a_eow", bus_a.out_eow, e.eow);
                    check("a_ovf", bus_a.ovf, e.ovf[0]);
                end
                last_a = bus_a.out_bit;
            end else begin
                check("a_idle_flags", {bus_a.out_eow, bus_a.ovf}, 0);
                check("a_idle_hold", bus_a.out_bit, last_a);
            end
            if (bus_b.out_valid) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL b_unexpected: got out_valid=1 expected no output at %0t", $time);
                end else begin
                    e = qb.pop_front();
                    check("b_bits", bus_b.out_bit, e.bits);
                    check("b_eow", bus_b.out_eow, e.eow);
                    check("b_ovf", bus_b.ovf, e.ovf);
                end
                last_b = bus_b.out_bit;
            end else begin
                check("b_idle_flags", {bus_b.out_eow, bus_b.ovf}, 0);
                check("b_idle_hold", bus_b.out_bit, last_b);
            end
        end
    end

    initial begin
        logic [3:0][7:0] x;
        bus_a.in_valid = 1'b0; bus_a.in_sof = 1'b0; bus_a.in_bit = '0; bus_a.mode = '0;
        bus_b.in_valid = 1'b0; bus_b.in_sof = 1'b0; bus_b.in_bit = '0; bus_b.mode = '0;
        #1 r_n = 1'b0;
        repeat (3) tick();
        r_n = 1'b1;
        aligned[0] = 1'b1;
        aligned[1] = 1'b1;
        tick();

        // First word after reset without sof; negate 6 -> 10.
        send_word(0, 32'd6, 4'b0001, 4, 1'b0, -1, 0);
        // Wrap without sof; negate -8 (overflow), then same word passed through.
        send_word(0, 32'd8, 4'b0001, 4, 1'b0, -1, 0);
        send_word(0, 32'd8, 4'b0000, 4, 1'b1, -1, 0);
        // Four lanes, modes 1,0,1,0 on inputs 1,1,0,0x80.
        send_word(1, {8'h80, 8'h00, 8'h01, 8'h01}, 4'b0101, 8, 1'b1, -1, 0);
        // Two idle cycles between bits 1 and 2.
        send_word(0, 32'd3, 4'b0001, 4, 1'b1, 2, 2);
        // Abort after two bits, then a new word 1 negated -> 15.
        send_word(0, 32'd5, 4'b0001, 2, 1'b1, -1, 0);
        send_word(0, 32'd1, 4'b0001, 4, 1'b1, -1, 0);
        // Reset mid-word; the next valid bit must be bit 0 without sof.
        send_word(0, 32'd6, 4'b0001, 2, 1'b1, -1, 0);
        r_n = 1'b0;
        qa.delete();
        qb.delete();
        repeat (2) tick();
        r_n = 1'b1;
        aligned[0] = 1'b1;
        aligned[1] = 1'b1;
        tick();
        send_word(0, 32'd7, 4'b0001, 4, 1'b0, -1, 0);
        send_word(1, {8'h80, 8'h80, 8'h7F, 8'hFF}, 4'b1111, 8, 1'b0, -1, 0);

        for (int it = 0; it < 300; it++) begin
            int  d      = int'($urandom_range(0, 1));
            int  w      = (d == 0) ? 4 : 8;
            int  nbits  = ($urandom_range(0, 4) != 0) ? w : int'($urandom_range(1, w - 1));
            bit  sof    = aligned[d] ? 1'($urandom) : 1'b1;
            int  gap_at = int'($urandom_range(0, w + 3));
            int  gap_ln = int'($urandom_range(1, 3));
            logic [3:0] md = 4'($urandom);
            x = $urandom;
            if ($urandom_range(0, 7) == 0)
                x[0] = 8'(1 << (w - 1));
            send_word(d, x, md, nbits, sof, gap_at, gap_ln);
            if ($urandom_range(0, 3) == 0)
                tick();
        end

        repeat (3) tick();
        check("a_drain", qa.size(), 0);
        check("b_drain", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_twos_comp_mc.md
SERIAL_TWOS_COMP_MC -- requirements
Module: serial_twos_comp_mc

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the word length in bits (legal W >= 2).
REQ-002 The block SHALL have parameter N, default 4, giving the number of independent serial lanes.
REQ-003 t_clk  input  1  Single clock; all state SHALL change on its rising edge.
REQ-004 r_n  input  1  Reset; asynchronous, active-low.
REQ-005 in_valid  input  1  The in_bit lanes carry a bit this cycle.
REQ-006 in_sof  input  1  Qualified by in_valid; the current bit is bit 0 (LSB) of a new word on every lane.
REQ-007 in_bit  input  N  Serial input bits, one per lane, sent LSB first.
REQ-008 mode  input  N  Per-lane mode, sampled on bit 0 only: 0 = pass-through, 1 = two's-complement negate.
REQ-009 out_valid  output  1  The out_bit lanes carry a result bit.
REQ-010 out_bit  output  N  Serial result bits, LSB first.
REQ-011 out_eow  output  1  Qualified by out_valid; out_bit is the last bit (MSB) of the word.
REQ-012 ovf  output  N  Per-lane overflow flag; it is valid only when out_eow is 1.

Function
REQ-013 A shared bit counter k (0..W-1) SHALL advance only on cycles with in_valid=1.
- k is 0 on the first valid bit after reset, on any valid bit with in_sof=1, and after a valid bit at k=W-1 (wrap).
REQ-014 Each lane SHALL run a two-state FSM: COPY and INVERT.
- The lane enters COPY at k=0 before that bit is processed.
- A negate-mode lane moves COPY->INVERT after it outputs the first 1 bit.
- A pass-mode lane stays in COPY.
REQ-015 Lane output for a valid bit:
- COPY: out = in.
- INVERT: out = ~in.
- Result: pass mode outputs x unchanged; negate mode outputs (-x) mod 2^W.
REQ-016 The mode used on bit 0 SHALL be the live mode input; bits 1..W-1 SHALL use the mode latched at bit 0.
REQ-017 Outputs SHALL be registered with latency exactly 1 cycle.
- out_valid(t+1) = in_valid(t).
- out_bit and out_eow relate to the input bit accepted at t.
REQ-018 out_eow SHALL be 1 exactly when out_valid=1 and the corresponding input bit had k=W-1.
REQ-019 ovf[i] SHALL be 1 with out_eow only for a negate-mode lane whose input word was -2^(W-1) (MSB=1, all lower bits 0).
- ovf[i] SHALL be 0 in every other case.
REQ-020 While in_valid=0:
- out_valid SHALL be 0, with out_eow=0 and ovf=0.
- out_bit SHALL hold its last value.
- k, the lane FSMs and the latched modes SHALL hold.
REQ-021 in_sof=1 mid-word SHALL abandon the partial word without an out_eow and restart at k=0 with that bit.
REQ-022 in_sof=1 at k=W-1 wrap SHALL be treated identically to a normal bit 0 (no conflict).
REQ-023 in_sof with in_valid=0 SHALL be ignored.

Reset
REQ-024 While r_n=0:
- out_valid, out_bit, out_eow and ovf SHALL be 0.
- k SHALL be 0.
- Every lane SHALL be in COPY with latched mode 0.
REQ-025 Reset asserted mid-word SHALL discard the word; the first valid bit after release SHALL be bit 0.

Structure
REQ-026 A shared package stc_pkg SHALL hold the lane-state enum (COPY, INVERT) and the constant STC_MIN_W = 2.
REQ-027 Per-lane logic SHALL be in sub-module stc_lane, instantiated N times.
- stc_lane holds the FSM, the latched mode and the overflow tracking.
- The top level holds the counter and the output valid/eow registers.

Verification
REQ-028 W=4, N=1, mode=1, input 6 (LSB-first 0,1,1,0) -> out 0,1,0,1 (=10); out_eow on the 4th output; ovf=0.
REQ-029 W=4, mode=1, input -8 (0,0,0,1) -> out 0,0,0,1; ovf=1 with out_eow. The same word in mode=0 -> ovf=0.
REQ-030 W=8, N=4, modes 1,0,1,0, inputs 1, 1, 0, 0x80 -> outputs 0xFF, 0x01, 0x00, 0x80; ovf=0000.
REQ-031 W=4, mode=1, input 3 with in_valid low for 2 cycles between bits 1 and 2:
- out = 13 (1,0,1,1).
- out_valid is low for exactly those 2 cycles.
- out_bit holds during the gap.
REQ-032 in_sof at k=2 mid-word, then word 1 (W=4, mode=1) -> no out_eow for the aborted word; new word out = 15 (1,1,1,1).
REQ-033 r_n pulsed low at k=2 -> all outputs 0 during reset; the next valid bit is treated as bit 0.
